// File: rtl/eqa_coeff_loader_pkg.sv
// Shared types and defaults for the equaliser coefficient loader.
package eqa_coeff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TAP,
    ST_SET,
    ST_DONE
  } state_t;

  localparam int DEFAULT_NUM_BANDS   = 5;
  localparam int DEFAULT_NUM_TAPS    = 5;
  localparam int DEFAULT_COEFF_WIDTH = 18;

  // Index of the lowest set bit; bands are addressed with 3 bits, so 8 is the ceiling.
  function automatic logic [2:0] lowest_band(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/eqa_coeff_table.sv
// Shadow coefficient storage: one host write port, a combinational load port and,
// with EQA_COEFF_READBACK_EN, a registered host read port.
module eqa_coeff_table
  import eqa_coeff_loader_pkg::*;
#(
  parameter int NUM_BANDS              = DEFAULT_NUM_BANDS,
  parameter int NUM_TAPS               = DEFAULT_NUM_TAPS,
  parameter int COEFFICIENT_DATA_WIDTH = DEFAULT_COEFF_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_en,
  input  logic [2:0]                        wr_band,
  input  logic [2:0]                        wr_idx,
  input  logic [COEFFICIENT_DATA_WIDTH-1:0] wr_a,
  input  logic [COEFFICIENT_DATA_WIDTH-1:0] wr_b,
  input  logic [2:0]                        ld_band,
  input  logic [2:0]                        ld_idx,
  output logic [COEFFICIENT_DATA_WIDTH-1:0] ld_a,
  output logic [COEFFICIENT_DATA_WIDTH-1:0] ld_b
`ifdef EQA_COEFF_READBACK_EN
  ,
  input  logic [2:0]                        rd_band,
  input  logic [2:0]                        rd_idx,
  output logic [COEFFICIENT_DATA_WIDTH-1:0] rd_a,
  output logic [COEFFICIENT_DATA_WIDTH-1:0] rd_b
`endif
);

  logic [COEFFICIENT_DATA_WIDTH-1:0] mem_a [NUM_BANDS][NUM_TAPS];
  logic [COEFFICIENT_DATA_WIDTH-1:0] mem_b [NUM_BANDS][NUM_TAPS];

  // The loader only asserts wr_en for in-range addresses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        for (int j = 0; j < NUM_TAPS; j++) begin
          mem_a[i][j] <= '0;
          mem_b[i][j] <= '0;
        end
      end
    end else if (wr_en) begin
      mem_a[wr_band][wr_idx] <= wr_a;
      mem_b[wr_band][wr_idx] <= wr_b;
    end
  end

  assign ld_a = mem_a[ld_band][ld_idx];
  assign ld_b = mem_b[ld_band][ld_idx];

`ifdef EQA_COEFF_READBACK_EN
  localparam logic [3:0] BAND_LIM = 4'(NUM_BANDS);
  localparam logic [3:0] TAP_LIM  = 4'(NUM_TAPS);

  logic rd_ok;
  assign rd_ok = ({1'b0, rd_band} < BAND_LIM) && ({1'b0, rd_idx} < TAP_LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_a <= '0;
      rd_b <= '0;
    end else if (rd_ok) begin
      rd_a <= mem_a[rd_band][rd_idx];
      rd_b <= mem_b[rd_band][rd_idx];
    end else begin
      rd_a <= '0;
      rd_b <= '0;
    end
  end
`endif

endmodule

// File: rtl/eqa_coeff_loader.sv
// Streams shadow-table coefficients into the selected equaliser bands on commit.
// Optional host readback of the shadow table: define EQA_COEFF_READBACK_EN.
module eqa_coeff_loader
  import eqa_coeff_loader_pkg::*;
#(
  parameter int NUM_BANDS              = DEFAULT_NUM_BANDS,
  parameter int NUM_TAPS               = DEFAULT_NUM_TAPS,
  parameter int COEFFICIENT_DATA_WIDTH = DEFAULT_COEFF_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cfg_wr,
  input  logic [2:0]                        cfg_band,
  input  logic [2:0]                        cfg_idx,
  input  logic [COEFFICIENT_DATA_WIDTH-1:0] cfg_a,
  input  logic [COEFFICIENT_DATA_WIDTH-1:0] cfg_b,
  input  logic                              cfg_commit,
  input  logic [NUM_BANDS-1:0]              cfg_mask,
  output logic                              cfg_err,
  output logic                              busy,
  output logic                              load_done,
  output logic                              eqa_hold,
  output logic [COEFFICIENT_DATA_WIDTH-1:0] coeff_a,
  output logic [COEFFICIENT_DATA_WIDTH-1:0] coeff_b,
  output logic [NUM_BANDS-1:0]              coeff_we,
  output logic [NUM_BANDS-1:0]              coeff_set
`ifdef EQA_COEFF_READBACK_EN
  ,
  input  logic [2:0]                        rd_band,
  input  logic [2:0]                        rd_idx,
  output logic [COEFFICIENT_DATA_WIDTH-1:0] rd_a,
  output logic [COEFFICIENT_DATA_WIDTH-1:0] rd_b
`endif
);

  localparam logic [3:0] BAND_LIM = 4'(NUM_BANDS);
  localparam logic [3:0] TAP_LIM  = 4'(NUM_TAPS);
  localparam logic [2:0] TAP_LAST = 3'(NUM_TAPS - 1);

  state_t                            state, state_n;
  logic [NUM_BANDS-1:0]              mask_q, mask_n;
  logic [2:0]                        band_q, band_n;
  logic [2:0]                        tap_q, tap_n;
  logic                              err_q;
  logic [COEFFICIENT_DATA_WIDTH-1:0] hold_a, hold_b;
  logic [COEFFICIENT_DATA_WIDTH-1:0] ld_a, ld_b;
  logic [NUM_BANDS-1:0]              band_onehot;
  logic [NUM_BANDS-1:0]              remaining;
  logic                              idle;
  logic                              in_range;
  logic                              wr_ok;
  logic                              err_set;

  assign idle        = (state == ST_IDLE);
  assign in_range    = ({1'b0, cfg_band} < BAND_LIM) && ({1'b0, cfg_idx} < TAP_LIM);
  assign wr_ok       = cfg_wr && idle && in_range;
  assign err_set     = (cfg_wr && !wr_ok) || (cfg_commit && !idle);
  assign band_onehot = {{(NUM_BANDS-1){1'b0}}, 1'b1} << band_q;
  assign remaining   = mask_q & ~band_onehot;

  eqa_coeff_table #(
    .NUM_BANDS              (NUM_BANDS),
    .NUM_TAPS               (NUM_TAPS),
    .COEFFICIENT_DATA_WIDTH (COEFFICIENT_DATA_WIDTH)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_band (cfg_band),
    .wr_idx  (cfg_idx),
    .wr_a    (cfg_a),
    .wr_b    (cfg_b),
    .ld_band (band_q),
    .ld_idx  (tap_q),
    .ld_a    (ld_a),
    .ld_b    (ld_b)
`ifdef EQA_COEFF_READBACK_EN
    ,
    .rd_band (rd_band),
    .rd_idx  (rd_idx),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
`endif
  );

  // The bus keeps the last streamed tap so band inputs stay quiet between loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      mask_q <= '0;
      band_q <= '0;
      tap_q  <= '0;
      err_q  <= 1'b0;
      hold_a <= '0;
      hold_b <= '0;
    end else begin
      state  <= state_n;
      mask_q <= mask_n;
      band_q <= band_n;
      tap_q  <= tap_n;
      err_q  <= err_set;
      if (state == ST_TAP) begin
        hold_a <= ld_a;
        hold_b <= ld_b;
      end
    end
  end

  always_comb begin
    state_n   = state;
    mask_n    = mask_q;
    band_n    = band_q;
    tap_n     = tap_q;
    coeff_we  = '0;
    coeff_set = '0;
    load_done = 1'b0;
    coeff_a   = hold_a;
    coeff_b   = hold_b;
    case (state)
      ST_IDLE: begin
        if (cfg_commit) begin
          mask_n  = cfg_mask;
          band_n  = lowest_band(8'(cfg_mask));
          tap_n   = '0;
          state_n = (cfg_mask != '0) ? ST_TAP : ST_DONE;
        end
      end
      ST_TAP: begin
        coeff_we = band_onehot;
        coeff_a  = ld_a;
        coeff_b  = ld_b;
        if (tap_q == TAP_LAST) state_n = ST_SET;
        else                   tap_n   = tap_q + 3'd1;
      end
      ST_SET: begin
        coeff_set = band_onehot;
        mask_n    = remaining;
        tap_n     = '0;
        if (remaining != '0) begin
          band_n  = lowest_band(8'(remaining));
          state_n = ST_TAP;
        end else begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        load_done = 1'b1;
        state_n   = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy     = !idle;
  assign eqa_hold = !idle;
  assign cfg_err  = err_q;

endmodule

// File: tb/tb_eqa_coeff_loader.sv
// Directed bench for eqa_coeff_loader: vector table plus hand-written multi-cycle sequences.
module tb_eqa_coeff_loader;

  localparam int NB = 5;
  localparam int NT = 5;
  localparam int W  = 18;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_wr = 1'b0;
  logic [2:0]    cfg_band = '0;
  logic [2:0]    cfg_idx = '0;
  logic [W-1:0]  cfg_a = '0;
  logic [W-1:0]  cfg_b = '0;
  logic          cfg_commit = 1'b0;
  logic [NB-1:0] cfg_mask = '0;
  logic          cfg_err, busy, load_done, eqa_hold;
  logic [W-1:0]  coeff_a, coeff_b;
  logic [NB-1:0] coeff_we, coeff_set;
`ifdef EQA_COEFF_READBACK_EN
  logic [2:0]    rd_band = '0;
  logic [2:0]    rd_idx = '0;
  logic [W-1:0]  rd_a, rd_b;
`endif

  eqa_coeff_loader dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_wr     (cfg_wr),
    .cfg_band   (cfg_band),
    .cfg_idx    (cfg_idx),
    .cfg_a      (cfg_a),
    .cfg_b      (cfg_b),
    .cfg_commit (cfg_commit),
    .cfg_mask   (cfg_mask),
    .cfg_err    (cfg_err),
    .busy       (busy),
    .load_done  (load_done),
    .eqa_hold   (eqa_hold),
    .coeff_a    (coeff_a),
    .coeff_b    (coeff_b),
    .coeff_we   (coeff_we),
    .coeff_set  (coeff_set)
`ifdef EQA_COEFF_READBACK_EN
    ,
    .rd_band    (rd_band),
    .rd_idx     (rd_idx),
    .rd_a       (rd_a),
    .rd_b       (rd_b)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [W-1:0] mdl_a [NB][NT];
  logic [W-1:0] mdl_b [NB][NT];
  logic [W-1:0] last_a = '0;
  logic [W-1:0] last_b = '0;

  typedef struct {
    logic          wr;
    logic [2:0]    band;
    logic [2:0]    idx;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          commit;
    logic [NB-1:0] mask;
    logic [49:0]   exp;
    string         name;
  } vec_t;

  vec_t vecs[$];

  // Expected output word: {err, busy, hold, done, we, set, a, b}; hold always mirrors busy.
  function automatic logic [49:0] pack_exp(input logic err, input logic bsy, input logic done,
                                           input logic [4:0] we, input logic [4:0] set,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    return {err, bsy, bsy, done, we, set, a, b};
  endfunction

  function automatic vec_t mk(input logic wr, input logic [2:0] band, input logic [2:0] idx,
                              input logic [W-1:0] a, input logic [W-1:0] b, input logic commit,
                              input logic [NB-1:0] mask, input logic [49:0] exp, input string name);
    vec_t v;
    v.wr = wr; v.band = band; v.idx = idx; v.a = a; v.b = b;
    v.commit = commit; v.mask = mask; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic wr, input logic [2:0] band, input logic [2:0] idx,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic commit, input logic [NB-1:0] mask);
    cfg_wr     = wr;
    cfg_band   = band;
    cfg_idx    = idx;
    cfg_a      = a;
    cfg_b      = b;
    cfg_commit = commit;
    cfg_mask   = mask;
  endtask

  task automatic idle_inputs();
    apply_stimulus(1'b0, 3'd0, 3'd0, '0, '0, 1'b0, '0);
  endtask

  task automatic check_output(input string name, input logic [49:0] exp);
    logic [49:0] act;
    act = {cfg_err, busy, eqa_hold, load_done, coeff_we, coeff_set, coeff_a, coeff_b};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NB; i++)
      for (int j = 0; j < NT; j++) begin
        mdl_a[i][j] = '0;
        mdl_b[i][j] = '0;
      end
    last_a = '0;
    last_b = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    clear_model();
    tick();
    tick();
    check_output("in_reset", pack_exp(0, 0, 0, 5'b0, 5'b0, '0, '0));
    reset = 1'b0;
    tick();
    check_output("after_reset", pack_exp(0, 0, 0, 5'b0, 5'b0, '0, '0));
  endtask

  task automatic write_entry(input logic [2:0] band, input logic [2:0] idx,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    apply_stimulus(1'b1, band, idx, a, b, 1'b0, '0);
    mdl_a[band][idx] = a;
    mdl_b[band][idx] = b;
    tick();
    check_output("write", pack_exp(0, 0, 0, 5'b0, 5'b0, last_a, last_b));
    idle_inputs();
  endtask

  // Commit and follow the whole sequence cycle by cycle against the bench model.
  task automatic run_commit(input logic [NB-1:0] mask, input bit inject, input bit same_wr,
                            input string name);
    logic [49:0] exp_q[$];
    logic [49:0] tmp;
    logic [W-1:0] la, lb;
    logic [4:0] oh;
    int busy_cnt, done_cnt, exp_busy;
    busy_cnt = 0;
    done_cnt = 0;
    if (same_wr) begin
      apply_stimulus(1'b1, 3'd3, 3'd0, 18'h333, 18'h334, 1'b1, mask);
      mdl_a[3][0] = 18'h333;
      mdl_b[3][0] = 18'h334;
    end else begin
      apply_stimulus(1'b0, 3'd0, 3'd0, '0, '0, 1'b1, mask);
    end
    la = last_a;
    lb = last_b;
    for (int b = 0; b < NB; b++) begin
      if (mask[b]) begin
        oh = 5'b00001 << b;
        for (int t = 0; t < NT; t++) begin
          la = mdl_a[b][t];
          lb = mdl_b[b][t];
          exp_q.push_back(pack_exp(0, 1, 0, oh, 5'b0, la, lb));
        end
        exp_q.push_back(pack_exp(0, 1, 0, 5'b0, oh, la, lb));
      end
    end
    exp_q.push_back(pack_exp(0, 1, 1, 5'b0, 5'b0, la, lb));
    exp_q.push_back(pack_exp(0, 0, 0, 5'b0, 5'b0, la, lb));
    if (inject) begin
      tmp = exp_q[2];
      tmp[49] = 1'b1;
      exp_q[2] = tmp;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin
        if (inject && i == 2) apply_stimulus(1'b1, 3'd2, 3'd0, 18'h3AA, 18'h3AB, 1'b1, 5'b00001);
        else                  idle_inputs();
      end
      tick();
      busy_cnt += int'(busy);
      done_cnt += int'(load_done);
      check_output($sformatf("%s_c%0d", name, i), exp_q[i]);
    end
    idle_inputs();
    last_a = la;
    last_b = lb;
    exp_busy = $countones(mask) * (NT + 1) + 1;
    total++;
    if (busy_cnt != exp_busy || done_cnt != 1) begin
      bad++;
      $display("[TB] FAIL %s_len: busy=%0d done=%0d expected busy=%0d done=1",
               name, busy_cnt, done_cnt, exp_busy);
    end
  endtask

  initial begin
    logic [W-1:0] va, vb;
    int hits;

    do_reset();

    vecs.push_back(mk(0, 0, 0, '0, '0, 0, 5'b0, pack_exp(0, 0, 0, 5'b0, 5'b0, '0, '0), "idle"));
    vecs.push_back(mk(0, 0, 0, '0, '0, 1, 5'b00001,
                      pack_exp(0, 1, 0, 5'b00001, 5'b0, '0, '0), "zero_tap0"));
    for (int t = 1; t < NT; t++)
      vecs.push_back(mk(0, 0, 0, '0, '0, 0, 5'b0,
                        pack_exp(0, 1, 0, 5'b00001, 5'b0, '0, '0), "zero_tap"));
    vecs.push_back(mk(0, 0, 0, '0, '0, 0, 5'b0, pack_exp(0, 1, 0, 5'b0, 5'b00001, '0, '0), "zero_set"));
    vecs.push_back(mk(0, 0, 0, '0, '0, 0, 5'b0, pack_exp(0, 1, 1, 5'b0, 5'b0, '0, '0), "zero_done"));
    vecs.push_back(mk(0, 0, 0, '0, '0, 0, 5'b0, pack_exp(0, 0, 0, 5'b0, 5'b0, '0, '0), "zero_idle"));
    for (int t = 0; t < NT; t++)
      vecs.push_back(mk(1, 3'd2, 3'(t), 18'h100 + 18'(t), 18'h200 + 18'(t), 0, 5'b0,
                        pack_exp(0, 0, 0, 5'b0, 5'b0, '0, '0), "wr_b2"));
    vecs.push_back(mk(1, 3'd5, 3'd0, 18'h3FF, 18'h3FF, 0, 5'b0,
                      pack_exp(1, 0, 0, 5'b0, 5'b0, '0, '0), "bad_band"));
    vecs.push_back(mk(0, 0, 0, '0, '0, 0, 5'b0, pack_exp(0, 0, 0, 5'b0, 5'b0, '0, '0), "err_clear"));
    vecs.push_back(mk(1, 3'd2, 3'd5, 18'h3FF, 18'h3FF, 0, 5'b0,
                      pack_exp(1, 0, 0, 5'b0, 5'b0, '0, '0), "bad_idx"));
    vecs.push_back(mk(0, 0, 0, '0, '0, 0, 5'b0, pack_exp(0, 0, 0, 5'b0, 5'b0, '0, '0), "err_clear2"));
    vecs.push_back(mk(0, 0, 0, '0, '0, 1, 5'b00100,
                      pack_exp(0, 1, 0, 5'b00100, 5'b0, 18'h100, 18'h200), "b2_tap0"));
    for (int t = 1; t < NT; t++)
      vecs.push_back(mk(0, 0, 0, '0, '0, 0, 5'b0,
                        pack_exp(0, 1, 0, 5'b00100, 5'b0, 18'h100 + 18'(t), 18'h200 + 18'(t)),
                        "b2_tap"));
    vecs.push_back(mk(0, 0, 0, '0, '0, 0, 5'b0,
                      pack_exp(0, 1, 0, 5'b0, 5'b00100, 18'h104, 18'h204), "b2_set"));
    vecs.push_back(mk(0, 0, 0, '0, '0, 0, 5'b0,
                      pack_exp(0, 1, 1, 5'b0, 5'b0, 18'h104, 18'h204), "b2_done"));
    vecs.push_back(mk(0, 0, 0, '0, '0, 0, 5'b0,
                      pack_exp(0, 0, 0, 5'b0, 5'b0, 18'h104, 18'h204), "b2_idle"));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].wr, vecs[i].band, vecs[i].idx, vecs[i].a, vecs[i].b,
                     vecs[i].commit, vecs[i].mask);
      if (vecs[i].wr && vecs[i].band < 3'd5 && vecs[i].idx < 3'd5) begin
        mdl_a[vecs[i].band][vecs[i].idx] = vecs[i].a;
        mdl_b[vecs[i].band][vecs[i].idx] = vecs[i].b;
      end
      tick();
      check_output($sformatf("%s_v%0d", vecs[i].name, i), vecs[i].exp);
    end
    idle_inputs();
    last_a = 18'h104;
    last_b = 18'h204;

    for (int t = 0; t < NT; t++) begin
      write_entry(3'd0, 3'(t), 18'h010 + 18'(t), 18'h020 + 18'(t));
      write_entry(3'd4, 3'(t), 18'h040 + 18'(t), 18'h050 + 18'(t));
    end
    run_commit(5'b10001, 0, 0, "multi");
    run_commit(5'b00100, 1, 0, "busy_err");
    run_commit(5'b00100, 0, 0, "reload_b2");
    run_commit(5'b00000, 0, 0, "mask0");
    run_commit(5'b01000, 0, 1, "wr_commit");

    // Abort band 1 during its third tap; table contents are lost with the reset.
    for (int t = 0; t < NT; t++) write_entry(3'd1, 3'(t), 18'h500 + 18'(t), 18'h600 + 18'(t));
    apply_stimulus(1'b0, 3'd0, 3'd0, '0, '0, 1'b1, 5'b00010);
    for (int t = 0; t < 3; t++) begin
      tick();
      idle_inputs();
      va = 18'h500 + 18'(t);
      vb = 18'h600 + 18'(t);
      check_output($sformatf("abort_tap%0d", t), pack_exp(0, 1, 0, 5'b00010, 5'b0, va, vb));
    end
    #2;
    reset = 1'b1;
    #1;
    check_output("abort_now", pack_exp(0, 0, 0, 5'b0, 5'b0, '0, '0));
    clear_model();
    #2;
    reset = 1'b0;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (coeff_set[1] || load_done || busy) hits++;
    end
    total++;
    if (hits != 0) begin
      bad++;
      $display("[TB] FAIL abort_quiet: activity cycles=%0d expected 0", hits);
    end
    run_commit(5'b00010, 0, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eqa_coeff_loader.md
EQA_COEFF_LOADER -- requirements
Module: eqa_coeff_loader

Interface
REQ-001 Parameter NUM_BANDS, default 5: number of IIR equaliser bands served.
REQ-002 Parameter NUM_TAPS, default 5: coefficient pairs (a,b) per band, indexed 0..NUM_TAPS-1.
REQ-003 Parameter COEFFICIENT_DATA_WIDTH, default 18: width of each a/b coefficient.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cfg_wr  in  1  one-cycle host write strobe into the shadow table.
REQ-007 cfg_band  in  3  target band, 0..NUM_BANDS-1.
REQ-008 cfg_idx  in  3  target tap, 0..NUM_TAPS-1.
REQ-009 cfg_a / cfg_b  in  COEFFICIENT_DATA_WIDTH each  coefficient pair to store.
REQ-010 cfg_commit  in  1  one-cycle strobe: push shadow table to filters.
REQ-011 cfg_mask  in  NUM_BANDS  bands to load on commit; bit n = band n.
REQ-012 cfg_err  out  1  one-cycle pulse on a rejected write or commit.
REQ-013 busy  out  1  high while a load sequence runs.
REQ-014 load_done  out  1  one-cycle pulse when a sequence finishes.
REQ-015 eqa_hold  out  1  equals busy; upstream gates eqa_start with it.
REQ-016 coeff_a / coeff_b  out  COEFFICIENT_DATA_WIDTH each  shared coefficient bus, fanned out to every band.
REQ-017 coeff_we  out  NUM_BANDS  per-band tap write enable.
REQ-018 coeff_set  out  NUM_BANDS  per-band one-cycle apply strobe.

Function
REQ-019 Shadow table: NUM_BANDS x NUM_TAPS entries of {a,b}; cfg_wr while idle with band and idx in range writes one entry on that edge.
REQ-020 A cfg_wr with band >= NUM_BANDS or idx >= NUM_TAPS, or any cfg_wr while busy, leaves the table unchanged and pulses cfg_err the next cycle.
REQ-021 The FSM has four states: IDLE, TAP, SET and DONE.
REQ-022 IDLE -> TAP: cfg_commit with nonzero cfg_mask. cfg_mask is latched, the lowest set band is selected and the tap counter is cleared.
REQ-023 TAP: for each tap t from 0 to NUM_TAPS-1, one cycle drives coeff_a/coeff_b = table[band][t] with coeff_we[band]=1. After the last tap the FSM moves to SET.
REQ-024 SET: one cycle with coeff_set[band]=1 and coeff_we=0. The FSM then goes to TAP for the next set mask bit, or to DONE if none remain.
REQ-025 DONE: load_done=1 for one cycle, then IDLE.
REQ-026 Latency: a mask with k bands gives busy for k*(NUM_TAPS+1)+1 cycles, starting the cycle after the commit, with load_done in the last of those cycles.
REQ-027 cfg_commit with mask 0 goes straight to DONE: one load_done pulse, no we/set activity, and no cfg_err.
REQ-028 cfg_commit while busy is dropped and pulses cfg_err; the running sequence continues unaltered.
REQ-029 At most one bit of coeff_we or coeff_set is high in any cycle, and never both vectors at once.
REQ-030 Outside TAP, coeff_a/coeff_b hold their last value.
REQ-031 cfg_wr and cfg_commit in the same idle cycle: the write lands first, and the commit uses the updated table.

Reset
REQ-032 Reset asserted puts the FSM in IDLE and drives busy, eqa_hold, load_done, cfg_err, coeff_we and coeff_set to 0, and coeff_a/coeff_b to 0.
REQ-033 The shadow table resets to all zeros.
REQ-034 Reset during a sequence aborts it immediately, with no set strobe and no load_done.

Configuration
REQ-035 With EQA_COEFF_READBACK_EN defined, the block adds ports rd_band (in, 3), rd_idx (in, 3), rd_a and rd_b (out, COEFFICIENT_DATA_WIDTH), giving a registered read of the shadow table 1 cycle after the address is presented.
REQ-036 Without EQA_COEFF_READBACK_EN, those ports and the read logic are absent.

Structure
REQ-037 A shared package holds the FSM state enum, the default band and tap counts, and the coefficient width.
REQ-038 One sub-module, eqa_coeff_table (shadow storage with write port and read port), is instantiated once.

Verification
REQ-039 Reset test: hold reset, then release. Required: all outputs 0 and busy=0; a commit with mask 5'b00001 then loads zeros into band 0.
REQ-040 Single band: write band 2 taps 0..4 with a=0x100+t and b=0x200+t, then commit with mask 5'b00100. Required:
- coeff_we[2] is high for 5 cycles carrying those values in order.
- coeff_set[2] pulses once.
- load_done arrives 7 cycles after the commit.
REQ-041 Multi band: commit with mask 5'b10001. Required: the band 0 sequence, then the band 4 sequence, busy for 13 cycles, and a single load_done.
REQ-042 Errors:
- cfg_wr with band=5: cfg_err pulses and the table is unchanged.
- A commit while busy: cfg_err pulses and the original sequence completes.
- A commit with mask 0: load_done pulses after 1 cycle and no we/set activity occurs.
REQ-043 Reset mid-load: assert reset during the third tap of band 1. Required: coeff_we goes to 0 at once and no coeff_set[1] or load_done occurs.
